// File: rtl/irrigation_pkg.sv
// Shared types for the multi-zone irrigation controller:
// mode codes, zone state encoding and the sensor decode.
package irrigation_pkg;

    localparam logic [1:0] MODE_NONE     = 2'b00;
    localparam logic [1:0] MODE_ASP      = 2'b01;
    localparam logic [1:0] MODE_DRIP     = 2'b10;
    localparam logic [1:0] MODE_ASP_DRIP = 2'b11;

    typedef enum logic [1:0] {
        ZS_IDLE = 2'd0,
        ZS_WAIT = 2'd1,
        ZS_ASP  = 2'd2,
        ZS_DRIP = 2'd3
    } zone_state_e;

    function automatic logic [1:0] decode_mode(
        input logic t,
        input logic ua,
        input logic us
    );
        if (us)
            return MODE_NONE;
        else if (!ua)
            return MODE_ASP;
        else if (t)
            return MODE_DRIP;
        else
            return MODE_ASP_DRIP;
    endfunction

endpackage

// File: rtl/irrigation_zone_fsm.sv
// One irrigation zone: decode, valve sequencing, seconds counter
// and the request/grant handshake for the shared sprinkler line.
import irrigation_pkg::*;

module irrigation_zone_fsm #(
    parameter int ASP_SECS = 22,
    parameter int SEC_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_tick,
    input  logic       i_t,
    input  logic       i_ua,
    input  logic       i_us,
    input  logic       i_grant,
    output logic       o_req,
    output logic       o_keep,
    output logic       o_asp,
    output logic       o_drip,
    output logic [1:0] o_mode
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(ASP_SECS - 1);

    zone_state_e      r_state;
    zone_state_e      w_nxt;
    logic [SEC_W-1:0] r_sec;
    logic [1:0]       r_mode;
    logic [1:0]       w_dec;

    assign w_dec = decode_mode(i_t, i_ua, i_us);

    always_comb begin
        w_nxt = r_state;
        if (!i_en) begin
            w_nxt = ZS_IDLE;
        end else begin
            unique case (r_state)
                ZS_IDLE: begin
                    if (w_dec == MODE_DRIP)
                        w_nxt = ZS_DRIP;
                    else if (w_dec == MODE_ASP || w_dec == MODE_ASP_DRIP)
                        w_nxt = ZS_WAIT;
                end
                ZS_WAIT: begin
                    if (i_us)
                        w_nxt = ZS_IDLE;
                    else if (i_grant)
                        w_nxt = ZS_ASP;
                end
                ZS_ASP: begin
                    // Soil-wet exit takes priority over the switch tick
                    if (i_us)
                        w_nxt = ZS_IDLE;
                    else if (r_mode == MODE_ASP_DRIP && i_tick &&
                             r_sec == SEC_LAST)
                        w_nxt = ZS_DRIP;
                end
                ZS_DRIP: begin
                    if (i_us)
                        w_nxt = ZS_IDLE;
                end
                default: w_nxt = ZS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ZS_IDLE;
            r_sec   <= '0;
            r_mode  <= MODE_NONE;
        end else begin
            r_state <= w_nxt;
            if (r_state != ZS_ASP)
                r_sec <= '0;
            else if (i_tick)
                r_sec <= r_sec + 1'b1;
            if (r_state == ZS_IDLE || w_nxt == ZS_IDLE)
                r_mode <= w_dec;
        end
    end

    assign o_req  = (r_state == ZS_WAIT);
    assign o_keep = (w_nxt == ZS_WAIT) || (w_nxt == ZS_ASP);
    assign o_asp  = (r_state == ZS_ASP);
    assign o_drip = (r_state == ZS_DRIP);
    assign o_mode = r_mode;

endmodule

// File: rtl/irrigation_zone_controller.sv
// Multi-zone irrigation controller: prescaler, round-robin sprinkler
// arbiter and ZONES zone FSMs. Optional: IRRIGATION_WATER_GUARD_EN.
import irrigation_pkg::*;

module irrigation_zone_controller #(
    parameter int ZONES    = 4,
    parameter int TICK_DIV = 50000000,
    parameter int ASP_SECS = 22,
    parameter int SEC_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic [ZONES-1:0]   T,
    input  logic [ZONES-1:0]   Ua,
    input  logic [ZONES-1:0]   Us,
`ifdef IRRIGATION_WATER_GUARD_EN
    input  logic               water_ok,
    output logic               water_fault,
`endif
    output logic [2*ZONES-1:0] mode,
    output logic [ZONES-1:0]   asp_valve,
    output logic [ZONES-1:0]   drip_valve,
    output logic               asp_busy
);

    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PTR_W = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic             w_en;
    logic             w_tick;
    logic [PW-1:0]    r_pre;
    logic [ZONES-1:0] w_req;
    logic [ZONES-1:0] w_keep;
    logic [ZONES-1:0] w_cand;
    logic [ZONES-1:0] w_gnt;
    logic             r_own_vld;
    logic [PTR_W-1:0] r_own;
    logic [PTR_W-1:0] r_ptr;
    logic             w_pick_vld;
    logic [PTR_W-1:0] w_pick;

`ifdef IRRIGATION_WATER_GUARD_EN
    logic r_fault;

    assign w_en        = init & water_ok;
    assign water_fault = r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fault <= 1'b0;
        else if (!water_ok)
            r_fault <= 1'b1;
        else if (init)
            r_fault <= 1'b0;
    end
`else
    assign w_en = init;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pre <= '0;
        else if (!w_en || r_pre == PRE_LAST)
            r_pre <= '0;
        else
            r_pre <= r_pre + 1'b1;
    end

    assign w_tick = w_en && (r_pre == PRE_LAST);

    // Only zones that will still be waiting next cycle may win
    assign w_cand = w_req & w_keep;

    always_comb begin
        logic [PTR_W-1:0] v_idx;
        v_idx      = '0;
        w_pick_vld = 1'b0;
        w_pick     = r_ptr;
        for (int i = 1; i <= ZONES; i++) begin
            v_idx = PTR_W'((int'(r_ptr) + i) % ZONES);
            if (!w_pick_vld && w_cand[v_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = v_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own_vld <= 1'b0;
            r_own     <= '0;
            r_ptr     <= '0;
        end else if (!w_en) begin
            r_own_vld <= 1'b0;
        end else if (r_own_vld) begin
            if (!w_keep[r_own])
                r_own_vld <= 1'b0;
        end else if (w_pick_vld) begin
            r_own_vld <= 1'b1;
            r_own     <= w_pick;
            r_ptr     <= w_pick;
        end
    end

    always_comb begin
        w_gnt = '0;
        if (r_own_vld)
            w_gnt[r_own] = 1'b1;
    end

    for (genvar g = 0; g < ZONES; g++) begin : g_zone
        irrigation_zone_fsm #(
            .ASP_SECS (ASP_SECS),
            .SEC_W    (SEC_W)
        ) u_zone (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en),
            .i_tick  (w_tick),
            .i_t     (T[g]),
            .i_ua    (Ua[g]),
            .i_us    (Us[g]),
            .i_grant (w_gnt[g]),
            .o_req   (w_req[g]),
            .o_keep  (w_keep[g]),
            .o_asp   (asp_valve[g]),
            .o_drip  (drip_valve[g]),
            .o_mode  (mode[2*g +: 2])
        );
    end

    assign asp_busy = |asp_valve;

endmodule

// File: tb/tb_irrigation_zone_controller.sv
// Directed bench for irrigation_zone_controller
// (ZONES=4, TICK_DIV=4, ASP_SECS=3).
module tb_irrigation_zone_controller;

    localparam int ZN = 4;
    localparam int TD = 4;
    localparam int AS = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          init  = 1'b0;
    logic [ZN-1:0] T     = '0;
    logic [ZN-1:0] Ua    = '0;
    logic [ZN-1:0] Us    = '1;
    logic [2*ZN-1:0] mode;
    logic [ZN-1:0] asp_valve;
    logic [ZN-1:0] drip_valve;
    logic          asp_busy;
    logic          tb_en;

`ifdef IRRIGATION_WATER_GUARD_EN
    logic water_ok = 1'b1;
    logic water_fault;
    assign tb_en = init & water_ok;
`else
    assign tb_en = init;
`endif

    int checks = 0;
    int errors = 0;
    int tb_pre;

    irrigation_zone_controller #(
        .ZONES    (ZN),
        .TICK_DIV (TD),
        .ASP_SECS (AS),
        .SEC_W    (5)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init        (init),
        .T           (T),
        .Ua          (Ua),
        .Us          (Us),
`ifdef IRRIGATION_WATER_GUARD_EN
        .water_ok    (water_ok),
        .water_fault (water_fault),
`endif
        .mode        (mode),
        .asp_valve   (asp_valve),
        .drip_valve  (drip_valve),
        .asp_busy    (asp_busy)
    );

    always #5 clk = ~clk;

    // Reference prescaler: tick is the cycle where tb_pre == TD-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tb_pre <= 0;
        else if (!tb_en)
            tb_pre <= 0;
        else
            tb_pre <= (tb_pre == TD - 1) ? 0 : tb_pre + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int ticks;
        logic [1:0] mseen;
        logic found;
        logic hit;
        logic dseen;
        logic multi;
        logic [ZN-1:0] got;
        int ord [3];

        ord = '{0, 2, 3};

        repeat (2) step();
        chk("rst_mode", 32'(mode), 0);
        chk("rst_asp", 32'(asp_valve), 0);
        chk("rst_drip", 32'(drip_valve), 0);
        chk("rst_busy", 32'(asp_busy), 0);
        rst_n = 1'b1;
        step();

        // Zone 0 straight to drip, then soil-wet exit
        init = 1'b1;
        Ua[0] = 1'b1; T[0] = 1'b1; Us[0] = 1'b0;
        step(); step();
        chk("t1_mode", 32'(mode[1:0]), 2);
        chk("t1_drip", 32'(drip_valve[0]), 1);
        chk("t1_asp", 32'(asp_valve), 0);
        Us[0] = 1'b1;
        step();
        chk("t1_exit_drip", 32'(drip_valve[0]), 0);
        chk("t1_exit_mode", 32'(mode[1:0]), 0);

        // Zone 1 sprinkler-then-drip
        Ua[1] = 1'b1; T[1] = 1'b0; Us[1] = 1'b0;
        cnt = 0; mseen = 2'b00;
        for (int c = 0; c < 40; c++) begin
            step();
            if (asp_valve[1]) begin
                if (cnt == 0) mseen = mode[3:2];
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
        end
        chk("t2_mode", 32'(mseen), 3);
        chk("t2_asp_len_9to12", 32'(cnt >= 9 && cnt <= 12), 1);
        chk("t2_drip", 32'(drip_valve[1]), 1);
        chk("t2_asp_off", 32'(asp_valve[1]), 0);
        Us[1] = 1'b1;
        step();
        chk("t2_exit", 32'(drip_valve[1]), 0);

        // Zone 3 type 11, soil-wet on the switch tick
        Ua[3] = 1'b1; T[3] = 1'b0; Us[3] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (asp_valve[3]) begin found = 1'b1; break; end
        end
        chk("t3_asp_seen", 32'(found), 1);
        ticks = 0; hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (asp_valve[3] && tb_pre == TD - 1) begin
                if (ticks == AS - 1) begin
                    Us[3] = 1'b1; hit = 1'b1; break;
                end
                ticks++;
            end
            step();
        end
        chk("t3_switch_tick_found", 32'(hit), 1);
        step();
        chk("t3_asp_off", 32'(asp_valve[3]), 0);
        dseen = 1'b0;
        repeat (6) begin
            if (drip_valve[3]) dseen = 1'b1;
            step();
        end
        chk("t3_no_drip", 32'(dseen), 0);
        chk("t3_mode", 32'(mode[7:6]), 0);

        // Zones 0,2,3 contend for the sprinkler line
        Ua[0] = 1'b0; T[0] = 1'b0; Us[0] = 1'b0;
        Ua[2] = 1'b0; T[2] = 1'b0; Us[2] = 1'b0;
        Ua[3] = 1'b0; T[3] = 1'b0; Us[3] = 1'b0;
        multi = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got = '0;
            for (int c = 0; c < 12; c++) begin
                step();
                if ($countones(asp_valve) > 1) multi = 1'b1;
                if (asp_valve != '0) begin got = asp_valve; break; end
            end
            chk($sformatf("t4_grant%0d", k), 32'(got), 32'(1 << ord[k]));
            Us[ord[k]] = 1'b1;
            step();
            chk($sformatf("t4_release%0d", k), 32'(asp_valve[ord[k]]), 0);
        end
        chk("t4_onehot", 32'(multi), 0);

        // init dropped mid-sprinkler
        Us[2] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (asp_valve[2]) begin found = 1'b1; break; end
        end
        chk("t5_asp_seen", 32'(found), 1);
        init = 1'b0; Us[2] = 1'b1;
        step();
        chk("t5_asp", 32'(asp_valve), 0);
        chk("t5_busy", 32'(asp_busy), 0);
        chk("t5_drip", 32'(drip_valve), 0);

        // Asynchronous reset mid-drip
        init = 1'b1;
        Ua[0] = 1'b1; T[0] = 1'b1; Us[0] = 1'b0;
        step(); step();
        chk("t6_drip_on", 32'(drip_valve[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_drip", 32'(drip_valve), 0);
        chk("t6_async_mode", 32'(mode), 0);
        chk("t6_async_asp", 32'(asp_valve), 0);
        #1 rst_n = 1'b1;
        step();

`ifdef IRRIGATION_WATER_GUARD_EN
        step();
        chk("t7_drip_on", 32'(drip_valve[0]), 1);
        water_ok = 1'b0;
        step();
        chk("t7_drip_off", 32'(drip_valve[0]), 0);
        chk("t7_fault_set", 32'(water_fault), 1);
        water_ok = 1'b1;
        step();
        chk("t7_fault_clr", 32'(water_fault), 0);
        chk("t7_drip_back", 32'(drip_valve[0]), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
